// File: rtl/amber_wb_arb_pkg.sv
// ============================================================================
// Module      : amber_wb_arb_pkg
// Description : Shared types and constants for the Amber two-master Wishbone
//               arbiter: FSM state encoding, grant encoding, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package amber_wb_arb_pkg;

  // Arbiter FSM states. ABORT is only reachable when the watchdog is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  // One-hot grant encoding driven on o_grant.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Default bus widths of the Amber 128-bit bus.
  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 128;

endpackage

`default_nettype wire

// File: rtl/amber_wb_arb_watchdog.sv
// ============================================================================
// Module      : amber_wb_arb_watchdog
// Description : Stall watchdog for the arbiter. Counts clocks while the owner
//               strobes without a slave response; flags expiry when the count
//               has reached TIMEOUT and the slave is still silent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amber_wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,     // owner strobing, no ack/err this cycle
  input  logic i_clear,   // response seen or grant released
  output logic o_expire
);

  // Counter is at least 8 bits wide and always able to hold TIMEOUT.
  localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // Stall counter: clears on response/release, saturates at TIMEOUT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && (r_count != CW'(TIMEOUT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = i_run && (r_count == CW'(TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/amber_wb_arbiter.sv
// ============================================================================
// Module      : amber_wb_arbiter
// Description : Two-master / one-slave Wishbone arbiter for the Amber 128-bit
//               bus. Grant is locked for a whole cyc, ties alternate
//               round-robin, and every grant change passes through IDLE.
//               Optional stall watchdog: define AMBER_WB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amber_wb_arbiter
  import amber_wb_arb_pkg::*;
#(
  parameter int AW      = DEFAULT_AW,
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  // master 0 (Amber core)
  input  logic [AW-1:0]   i_m0_adr,
  input  logic [DW/8-1:0] i_m0_sel,
  input  logic            i_m0_we,
  input  logic [DW-1:0]   i_m0_dat,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  output logic [DW-1:0]   o_m0_dat,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  // master 1 (loader / injector)
  input  logic [AW-1:0]   i_m1_adr,
  input  logic [DW/8-1:0] i_m1_sel,
  input  logic            i_m1_we,
  input  logic [DW-1:0]   i_m1_dat,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  output logic [DW-1:0]   o_m1_dat,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  // slave
  output logic [AW-1:0]   o_s_adr,
  output logic [DW/8-1:0] o_s_sel,
  output logic            o_s_we,
  output logic [DW-1:0]   o_s_dat,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  input  logic [DW-1:0]   i_s_dat,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  // one-hot owner
  output logic [1:0]      o_grant
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_last;        // last owner; 1 after reset so master 0 wins first tie
  logic       w_last_next;

`ifdef AMBER_WB_ARB_TIMEOUT_EN
  logic w_owned;
  logic w_owner_stb;
  logic w_wd_run;
  logic w_wd_clear;
  logic w_expire;

  assign w_owned     = (r_state == GNT0) || (r_state == GNT1);
  assign w_owner_stb = (r_state == GNT0) ? (i_m0_cyc & i_m0_stb) :
                       (r_state == GNT1) ? (i_m1_cyc & i_m1_stb) : 1'b0;
  assign w_wd_run    = w_owned && w_owner_stb && !i_s_ack && !i_s_err;
  assign w_wd_clear  = !w_owned || i_s_ack || i_s_err;

  amber_wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_run    (w_wd_run),
    .i_clear  (w_wd_clear),
    .o_expire (w_expire)
  );
`else
  // TIMEOUT only matters to the watchdog; keep it referenced in this build.
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // State and last-owner registers; async reset drops any grant at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
    end
  end

  // Next-state decision plus the combinational bus mux for the current owner.
  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    o_s_adr     = '0;
    o_s_sel     = '0;
    o_s_we      = 1'b0;
    o_s_dat     = '0;
    o_s_cyc     = 1'b0;
    o_s_stb     = 1'b0;
    o_m0_dat    = '0;
    o_m0_ack    = 1'b0;
    o_m0_err    = 1'b0;
    o_m1_dat    = '0;
    o_m1_ack    = 1'b0;
    o_m1_err    = 1'b0;
    o_grant     = GRANT_NONE;

    case (r_state)
      IDLE: begin
        // On a tie, the master that did not own the bus last goes first.
        if (i_m0_cyc && (!i_m1_cyc || r_last)) begin
          w_next = GNT0;
        end else if (i_m1_cyc) begin
          w_next = GNT1;
        end
      end

      GNT0: begin
        o_grant  = GRANT_M0;
        o_s_adr  = i_m0_adr;
        o_s_sel  = i_m0_sel;
        o_s_we   = i_m0_we;
        o_s_dat  = i_m0_dat;
        o_s_cyc  = i_m0_cyc;
        o_s_stb  = i_m0_cyc & i_m0_stb;
        o_m0_dat = i_s_dat;
        o_m0_ack = i_s_ack;
        o_m0_err = i_s_err;
        if (!i_m0_cyc) begin
          w_next      = IDLE;
          w_last_next = 1'b0;
        end
`ifdef AMBER_WB_ARB_TIMEOUT_EN
        else if (w_expire) begin
          w_next      = ABORT;
          w_last_next = 1'b0;
          o_m0_err    = 1'b1;
        end
`endif
      end

      GNT1: begin
        o_grant  = GRANT_M1;
        o_s_adr  = i_m1_adr;
        o_s_sel  = i_m1_sel;
        o_s_we   = i_m1_we;
        o_s_dat  = i_m1_dat;
        o_s_cyc  = i_m1_cyc;
        o_s_stb  = i_m1_cyc & i_m1_stb;
        o_m1_dat = i_s_dat;
        o_m1_ack = i_s_ack;
        o_m1_err = i_s_err;
        if (!i_m1_cyc) begin
          w_next      = IDLE;
          w_last_next = 1'b1;
        end
`ifdef AMBER_WB_ARB_TIMEOUT_EN
        else if (w_expire) begin
          w_next      = ABORT;
          w_last_next = 1'b1;
          o_m1_err    = 1'b1;
        end
`endif
      end

`ifdef AMBER_WB_ARB_TIMEOUT_EN
      // Slave is cut off; r_last already names the aborted owner.
      ABORT: begin
        o_grant = r_last ? GRANT_M1 : GRANT_M0;
        if (!(r_last ? i_m1_cyc : i_m0_cyc)) begin
          w_next = IDLE;
        end
      end
`endif

      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_amber_wb_arbiter.sv
// ============================================================================
// Module      : tb_amber_wb_arbiter
// Description : Self-checking bench for amber_wb_arbiter: directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against an owner/last-owner behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_amber_wb_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 128;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 255;
`ifdef AMBER_WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0;
  logic [SW-1:0] m0_sel = '0, m1_sel = '0;
  logic          m0_we = 1'b0, m1_we = 1'b0;
  logic [DW-1:0] m0_dat = '0, m1_dat = '0;
  logic          m0_cyc = 1'b0, m1_cyc = 1'b0;
  logic          m0_stb = 1'b0, m1_stb = 1'b0;
  logic [DW-1:0] s_dat = '0;
  logic          s_ack = 1'b0, s_err = 1'b0;

  logic [DW-1:0] o_m0_dat, o_m1_dat, o_s_dat;
  logic          o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic [AW-1:0] o_s_adr;
  logic [SW-1:0] o_s_sel;
  logic          o_s_we, o_s_cyc, o_s_stb;
  logic [1:0]    o_grant;

  int n_checks = 0;
  int n_fail   = 0;

  amber_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_adr(m0_adr), .i_m0_sel(m0_sel), .i_m0_we(m0_we), .i_m0_dat(m0_dat),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_adr(m1_adr), .i_m1_sel(m1_sel), .i_m1_we(m1_we), .i_m1_dat(m1_dat),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_s_adr(o_s_adr), .o_s_sel(o_s_sel), .o_s_we(o_s_we), .o_s_dat(o_s_dat),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
    .i_s_dat(s_dat), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // owner: -1 nobody, 0/1 master index; last: master that owned the bus last
  int mdl_owner = -1;
  int mdl_last  = 1;
  bit mdl_abort = 1'b0;
  int mdl_cnt   = 0;

  function automatic bit owner_cyc();
    return (mdl_owner == 0) ? m0_cyc : (mdl_owner == 1) ? m1_cyc : 1'b0;
  endfunction

  function automatic bit owner_stb();
    return (mdl_owner == 0) ? (m0_cyc & m0_stb) : (mdl_owner == 1) ? (m1_cyc & m1_stb) : 1'b0;
  endfunction

  // owner has been left hanging for TIMEOUT clocks and the slave is still silent
  function automatic bit model_timeout();
    return TO_EN && (mdl_owner >= 0) && !mdl_abort && owner_stb() && !s_ack && !s_err
           && (mdl_cnt == TIMEOUT);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_owner <= -1;
      mdl_last  <= 1;
      mdl_abort <= 1'b0;
      mdl_cnt   <= 0;
    end else if (mdl_owner < 0) begin
      mdl_cnt <= 0;
      if (m0_cyc && m1_cyc) mdl_owner <= 1 - mdl_last;
      else if (m0_cyc)      mdl_owner <= 0;
      else if (m1_cyc)      mdl_owner <= 1;
    end else if (!owner_cyc()) begin
      mdl_last  <= mdl_owner;
      mdl_owner <= -1;
      mdl_abort <= 1'b0;
      mdl_cnt   <= 0;
    end else if (TO_EN && !mdl_abort) begin
      if (model_timeout()) begin
        mdl_abort <= 1'b1;
        mdl_cnt   <= 0;
      end else if (s_ack || s_err) begin
        mdl_cnt <= 0;
      end else if (owner_stb()) begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  // compare process: every falling edge, DUT vs model
  always @(negedge clk) begin : cmp
    logic [1:0]    eg;
    logic [AW-1:0] ea;
    logic [SW-1:0] es;
    logic          ew, ec, eb, to;
    logic [DW-1:0] ed, e0d, e1d;
    logic          e0a, e0e, e1a, e1e;
    eg = 2'b00; ea = '0; es = '0; ew = 0; ec = 0; eb = 0; ed = '0;
    e0d = '0; e1d = '0; e0a = 0; e0e = 0; e1a = 0; e1e = 0;
    to = model_timeout();
    if (mdl_owner == 0) eg = 2'b01;
    if (mdl_owner == 1) eg = 2'b10;
    if (mdl_owner == 0 && !mdl_abort) begin
      ea = m0_adr; es = m0_sel; ew = m0_we; ed = m0_dat; ec = m0_cyc; eb = m0_cyc & m0_stb;
      e0d = s_dat; e0a = s_ack; e0e = s_err | to;
    end else if (mdl_owner == 1 && !mdl_abort) begin
      ea = m1_adr; es = m1_sel; ew = m1_we; ed = m1_dat; ec = m1_cyc; eb = m1_cyc & m1_stb;
      e1d = s_dat; e1a = s_ack; e1e = s_err | to;
    end
    check("grant", o_grant, eg);
    check("s_ctrl", {o_s_adr, o_s_sel, o_s_we, o_s_cyc, o_s_stb}, {ea, es, ew, ec, eb});
    check("s_dat", o_s_dat, ed);
    check("m0_resp", {o_m0_ack, o_m0_err}, {e0a, e0e});
    check("m0_dat", o_m0_dat, e0d);
    check("m1_resp", {o_m1_ack, o_m1_err}, {e1a, e1e});
    check("m1_dat", o_m1_dat, e1d);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] pat;
    logic [AW-1:0] exp_adr;
    int acks, idle_gap, done0, done1, k;
    bit got0, got1;

    pat = {4{32'hF0801003}};
    #1 rst_n = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_grant", o_grant, 2'b00);
    check("rst_scyc", {o_s_cyc, o_s_stb, o_m0_ack, o_m1_ack}, 4'b0000);
    check("rst_m0dat", o_m0_dat, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single m0 read, slave acks in the first granted cycle
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    @(negedge clk);
    check("req_not_yet", o_grant, 2'b00);
    tick();
    check("m0_grant", o_grant, 2'b01);
    check("m0_sadr", o_s_adr, 32'h100);
    s_ack = 1; s_dat = pat;
    #1;
    check("m0_ack", o_m0_ack, 1'b1);
    check("m0_data", o_m0_dat, pat);
    check("m1_noack", o_m1_ack, 1'b0);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();

    // spurious slave ack while nobody owns the bus
    s_ack = 1; s_dat = {4{$urandom}};
    #1;
    check("spur_ack", {o_m0_ack, o_m1_ack}, 2'b00);
    tick();
    s_ack = 0;

    // contention: m1 goes first (m0 owned last), then strict alternation
    m0_cyc = 1; m0_stb = 1; m0_adr = $urandom;
    m1_cyc = 1; m1_stb = 1; m1_adr = $urandom;
    #1 s_ack = o_s_stb;
    acks = 0; idle_gap = 0; done0 = 0; done1 = 0;
    for (int c = 0; c < 80 && acks < 8; c++) begin
      @(negedge clk);
      if (o_grant == 2'b00) idle_gap++;
      got0 = o_m0_ack; got1 = o_m1_ack;
      if (got0 || got1) begin
        check("alt_owner", {got1, got0}, (acks % 2 == 0) ? 2'b10 : 2'b01);
        if (acks > 0) check("alt_gap", idle_gap, 1);
        idle_gap = 0;
        acks++;
      end
      tick();
      if (got0) begin m0_cyc = 0; m0_stb = 0; done0++; end
      else if (!m0_cyc && done0 < 4) begin m0_cyc = 1; m0_stb = 1; m0_adr = $urandom; end
      if (got1) begin m1_cyc = 0; m1_stb = 0; done1++; end
      else if (!m1_cyc && done1 < 4) begin m1_cyc = 1; m1_stb = 1; m1_adr = $urandom; end
      #1 s_ack = o_s_stb; s_dat = {4{$urandom}};
    end
    check("alt_count", acks, 8);
    tick();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
    tick(); tick();

    // m1 holds cyc over 3 beats while m0 waits
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
    for (int b = 0; b < 3; b++) begin
      exp_adr = 32'h200 + 32'(b * 16);
      m1_adr = exp_adr; s_ack = 1; s_dat = {4{$urandom}};
      @(negedge clk);
      check("hold_grant", o_grant, 2'b10);
      check("hold_adr", o_s_adr, exp_adr);
      check("hold_acks", {o_m0_ack, o_m1_ack}, 2'b01);
      tick();
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk);
    check("hold_drop", {o_grant, o_s_cyc}, 3'b100);
    tick();
    @(negedge clk);
    check("hold_idle", o_grant, 2'b00);
    tick();
    @(negedge clk);
    check("m0_after", o_grant, 2'b01);
    check("m0_after_adr", o_s_adr, 32'h300);
    tick();
    m0_cyc = 0; m0_stb = 0;
    tick(); tick();

    // asynchronous reset in the middle of an m1 cycle
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h400;
    tick();
    @(negedge clk);
    check("pre_rst", {o_grant, o_s_cyc}, 3'b101);
    #2 rst_n = 0; m0_cyc = 1; m0_stb = 1;
    #1;
    check("async_rst", {o_grant, o_s_cyc, o_s_stb}, 4'b0000);
    tick();
    rst_n = 1;
    @(negedge clk);
    check("post_rst_idle", o_grant, 2'b00);
    tick();
    @(negedge clk);
    check("post_rst_tie", o_grant, 2'b01);
    tick();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();

    // randomized traffic, checked by the compare process
    for (int c = 0; c < 2000; c++) begin
      if (m0_cyc) begin if ($urandom_range(3) == 0) m0_cyc = 0; end
      else if ($urandom_range(2) == 0) m0_cyc = 1;
      if (m1_cyc) begin if ($urandom_range(3) == 0) m1_cyc = 0; end
      else if ($urandom_range(2) == 0) m1_cyc = 1;
      m0_stb = ($urandom_range(3) != 0); m1_stb = ($urandom_range(3) != 0);
      m0_adr = $urandom; m1_adr = $urandom;
      m0_sel = 16'($urandom); m1_sel = 16'($urandom);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_dat = {$urandom, $urandom, $urandom, $urandom};
      m1_dat = {$urandom, $urandom, $urandom, $urandom};
      s_dat  = {$urandom, $urandom, $urandom, $urandom};
      s_ack  = ($urandom_range(1) == 0);
      s_err  = ($urandom_range(15) == 0);
      tick();
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_err = 0;
    tick(); tick(); tick();

`ifdef AMBER_WB_ARB_TIMEOUT_EN
    // stalled slave: watchdog aborts m0, then m1 gets the bus
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500;
    tick();
    k = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o_m0_err) begin k = c; break; end
      tick();
    end
    check("to_cycle", k, TIMEOUT);
    tick();
    m1_cyc = 1; m1_stb = 1;
    @(negedge clk);
    check("abort_state", {o_m0_err, o_s_cyc, o_s_stb, o_grant}, 5'b00001);
    tick();
    @(negedge clk);
    check("abort_hold", {o_s_cyc, o_m1_ack}, 2'b00);
    tick();
    m0_cyc = 0; m0_stb = 0;
    tick();
    @(negedge clk);
    check("abort_idle", o_grant, 2'b00);
    tick();
    @(negedge clk);
    check("abort_m1", o_grant, 2'b10);
    tick();
    m1_cyc = 0; m1_stb = 0;
    tick(); tick();
`else
    k = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
